// File: rtl/decimal_binary_entry.sv
// decimal_binary_entry: assembles decimal key codes (integer digits, point,
// one half-step fraction digit) into a saturated binary value plus half flag.
// One multiply-accumulate cycle per integer digit, valid/ready key handshake,
// and a one-cycle result pulse on enter.
module decimal_binary_entry #(
  parameter int DATA_W     = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  output logic              key_ready,
  output logic              result_valid,
  output logic [DATA_W-1:0] result_data,
  output logic              result_decimal,
  output logic              result_overflow,
  output logic [DATA_W-1:0] live_data,
  output logic              live_decimal,
  output logic              entry_err
);

  localparam int ACC_W = DATA_W + 4;
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [ACC_W-1:0] MAX_VAL = {4'b0000, {DATA_W{1'b1}}};

  localparam logic [3:0] K_POINT = 4'd10;
  localparam logic [3:0] K_ENTER = 4'd11;
  localparam logic [3:0] K_CLEAR = 4'd12;

  typedef enum logic [2:0] {S_IDLE, S_INT, S_CALC, S_FRAC, S_DONE} state_t;

  state_t            state, n_state;
  logic [ACC_W-1:0]  acc, n_acc, mac;
  logic [CNT_W-1:0]  count, n_count;
  logic [3:0]        digit, n_digit;
  logic              half, n_half, ovf, n_ovf, err, n_err;
  logic              frac_done, n_frac_done;
  logic [DATA_W-1:0] res_data, n_res_data;
  logic              res_dec, n_res_dec, res_ovf, n_res_ovf;
  logic              accept, is_digit, do_enter, do_clear;

  assign key_ready = (state == S_IDLE) || (state == S_INT) || (state == S_FRAC);
  assign accept    = key_valid && key_ready;
  assign is_digit  = key_code <= 4'd9;
  assign mac       = acc * ACC_W'(10) + ACC_W'(digit);

  // State and datapath registers; reset aborts any in-flight CALC/DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      acc       <= '0;
      count     <= '0;
      digit     <= '0;
      half      <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      frac_done <= 1'b0;
      res_data  <= '0;
      res_dec   <= 1'b0;
      res_ovf   <= 1'b0;
    end else begin
      state     <= n_state;
      acc       <= n_acc;
      count     <= n_count;
      digit     <= n_digit;
      half      <= n_half;
      ovf       <= n_ovf;
      err       <= n_err;
      frac_done <= n_frac_done;
      res_data  <= n_res_data;
      res_dec   <= n_res_dec;
      res_ovf   <= n_res_ovf;
    end
  end

  // Next-state: key decode per state, MAC in CALC, commit on enter, wipe on clear/DONE.
  always_comb begin
    n_state     = state;
    n_acc       = acc;
    n_count     = count;
    n_digit     = digit;
    n_half      = half;
    n_ovf       = ovf;
    n_err       = err;
    n_frac_done = frac_done;
    n_res_data  = res_data;
    n_res_dec   = res_dec;
    n_res_ovf   = res_ovf;
    do_enter    = 1'b0;
    do_clear    = 1'b0;

    case (state)
      S_IDLE, S_INT: begin
        if (accept) begin
          if (is_digit) begin
            if (count < CNT_W'(MAX_DIGITS)) begin
              n_digit = key_code;
              n_state = S_CALC;
            end else begin
              n_err = 1'b1;
            end
          end else if (key_code == K_POINT) n_state = S_FRAC;
          else if (key_code == K_ENTER)     do_enter = 1'b1;
          else if (key_code == K_CLEAR)     do_clear = 1'b1;
          else                              n_err = 1'b1;
        end
      end
      S_CALC: begin
        n_acc   = mac;
        n_count = count + 1'b1;
        if (mac > MAX_VAL) n_ovf = 1'b1;
        n_state = S_INT;
      end
      S_FRAC: begin
        if (accept) begin
          if (is_digit) begin
            // Only one half-step digit is meaningful; anything else flags the entry.
            if (frac_done) n_err = 1'b1;
            else begin
              n_frac_done = 1'b1;
              if (key_code == 4'd0)      n_half = 1'b0;
              else if (key_code == 4'd5) n_half = 1'b1;
              else                       n_err  = 1'b1;
            end
          end else if (key_code == K_ENTER) do_enter = 1'b1;
          else if (key_code == K_CLEAR)     do_clear = 1'b1;
          else                              n_err = 1'b1;
        end
      end
      S_DONE: do_clear = 1'b1;
      default: n_state = S_IDLE;
    endcase

    // Capture the result when enter lands so it is already stable during DONE.
    if (do_enter) begin
      n_res_data = ovf ? {DATA_W{1'b1}} : acc[DATA_W-1:0];
      n_res_dec  = half;
      n_res_ovf  = ovf;
      n_state    = S_DONE;
    end
    if (do_clear) begin
      n_state     = S_IDLE;
      n_acc       = '0;
      n_count     = '0;
      n_half      = 1'b0;
      n_ovf       = 1'b0;
      n_err       = 1'b0;
      n_frac_done = 1'b0;
    end
  end

  assign result_valid    = (state == S_DONE);
  assign result_data     = res_data;
  assign result_decimal  = res_dec;
  assign result_overflow = res_ovf;
  assign live_data       = ovf ? {DATA_W{1'b1}} : acc[DATA_W-1:0];
  assign live_decimal    = half;
  assign entry_err       = err;

endmodule

// File: tb/tb_decimal_binary_entry.sv
// Directed table-driven bench for decimal_binary_entry plus hand sequences for
// held-key handshake and reset during CALC.
module tb_decimal_binary_entry;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = '0;
  logic       key_ready, result_valid, result_decimal, result_overflow;
  logic       live_decimal, entry_err;
  logic [7:0] result_data, live_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_rdata = '0;

  decimal_binary_entry #(.DATA_W(8), .MAX_DIGITS(3)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .result_valid(result_valid), .result_data(result_data),
    .result_decimal(result_decimal), .result_overflow(result_overflow),
    .live_data(live_data), .live_decimal(live_decimal), .entry_err(entry_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic       rdy_mid;
    logic       rv;
    logic [7:0] rdata;
    logic       rdec;
    logic       rovf;
    logic [7:0] live;
    logic       ldec;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] c, input logic rm, input logic rv, input logic [7:0] rd,
                     input logic rdc, input logic ro, input logic [7:0] lv, input logic ld,
                     input logic e);
    vec_t v;
    v.code = c; v.rdy_mid = rm; v.rv = rv; v.rdata = rd; v.rdec = rdc; v.rovf = ro;
    v.live = lv; v.ldec = ld; v.err = e;
    vecs.push_back(v);
  endtask

  // One key: present for one edge, check mid state, then check settled state.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    chk("ready_pre", idx, key_ready, 1);
    key_code  = v.code;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    chk("ready_mid", idx, key_ready, v.rdy_mid);
    chk("rv_mid", idx, result_valid, v.rv);
    if (v.rv) begin
      chk("rdata", idx, result_data, v.rdata);
      chk("rdec", idx, result_decimal, v.rdec);
      chk("rovf", idx, result_overflow, v.rovf);
      last_rdata = v.rdata;
    end
    @(posedge clk); #1;
    chk("rv_after", idx, result_valid, 0);
    chk("live", idx, live_data, v.live);
    chk("ldec", idx, live_decimal, v.ldec);
    chk("err", idx, entry_err, v.err);
    chk("rdata_hold", idx, result_data, last_rdata);
  endtask

  initial begin
    // code rdy_mid rv rdata rdec rovf live ldec err
    // 123 enter
    add(1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(2, 0, 0, 0, 0, 0, 12, 0, 0);
    add(3, 0, 0, 0, 0, 0, 123, 0, 0);
    add(11, 0, 1, 123, 0, 0, 0, 0, 0);
    // 256 saturates, 255 does not
    add(2, 0, 0, 0, 0, 0, 2, 0, 0);
    add(5, 0, 0, 0, 0, 0, 25, 0, 0);
    add(6, 0, 0, 0, 0, 0, 255, 0, 0);
    add(11, 0, 1, 255, 0, 1, 0, 0, 0);
    add(2, 0, 0, 0, 0, 0, 2, 0, 0);
    add(5, 0, 0, 0, 0, 0, 25, 0, 0);
    add(5, 0, 0, 0, 0, 0, 255, 0, 0);
    add(11, 0, 1, 255, 0, 0, 0, 0, 0);
    // 4.5 and .3
    add(4, 0, 0, 0, 0, 0, 4, 0, 0);
    add(10, 1, 0, 0, 0, 0, 4, 0, 0);
    add(5, 1, 0, 0, 0, 0, 4, 1, 0);
    add(11, 0, 1, 4, 1, 0, 0, 0, 0);
    add(10, 1, 0, 0, 0, 0, 0, 0, 0);
    add(3, 1, 0, 0, 0, 0, 0, 0, 1);
    add(11, 0, 1, 0, 0, 0, 0, 0, 0);
    // fourth digit dropped, then clear
    add(1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(2, 0, 0, 0, 0, 0, 12, 0, 0);
    add(3, 0, 0, 0, 0, 0, 123, 0, 0);
    add(4, 1, 0, 0, 0, 0, 123, 0, 1);
    add(12, 1, 0, 0, 0, 0, 0, 0, 0);
    // illegal code, second fraction digit, bare .5
    add(14, 1, 0, 0, 0, 0, 0, 0, 1);
    add(12, 1, 0, 0, 0, 0, 0, 0, 0);
    add(10, 1, 0, 0, 0, 0, 0, 0, 0);
    add(5, 1, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 1, 1);
    add(11, 0, 1, 0, 1, 0, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_live", 0, live_data, 0);
    chk("rst_rv", 0, result_valid, 0);
    chk("rst_rdata", 0, result_data, 0);
    chk("rst_err", 0, entry_err, 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) apply(vecs[i], i);

    // Held key across CALC is consumed once
    @(negedge clk);
    key_code = 4'd7; key_valid = 1'b1;
    @(posedge clk); #1;
    chk("hold_ready_calc", 100, key_ready, 0);
    @(posedge clk); #1;
    chk("hold_ready_int", 101, key_ready, 1);
    chk("hold_live", 101, live_data, 7);
    key_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_live_final", 102, live_data, 7);
    chk("hold_rv", 102, result_valid, 0);
    apply('{4'd12, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0}, 103);

    // Reset during CALC after digit 9
    @(negedge clk);
    key_code = 4'd9; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    chk("rc_in_calc", 200, key_ready, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rc_live", 201, live_data, 0);
    chk("rc_rv", 201, result_valid, 0);
    chk("rc_rdata", 201, result_data, 0);
    chk("rc_rovf", 201, result_overflow, 0);
    chk("rc_err", 201, entry_err, 0);
    last_rdata = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rc_idle_ready", 202, key_ready, 1);
    chk("rc_live2", 202, live_data, 0);
    chk("rc_rv2", 202, result_valid, 0);
    apply('{4'd9, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd9, 1'b0, 1'b0}, 203);
    apply('{4'd11, 1'b0, 1'b1, 8'd9, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0}, 204);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
